// File: rtl/rad4_booth_pkg.sv
// Shared types and elaboration helpers for the radix-4 Booth sequential multiplier.
package rad4_booth_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // One Booth digit retires per cycle, so the counter spans W/2 iterations.
  function automatic int cnt_w(input int w);
    return (w / 2 > 1) ? $clog2(w / 2) : 1;
  endfunction

  function automatic bit w_legal(input int w);
    return (w >= 4) && (w % 2 == 0);
  endfunction

endpackage

// File: rtl/rad4_booth_encoder.sv
// Radix-4 Booth digit encoder: bit triplet {x(2i+1), x(2i), x(2i-1)} to single/double/negative.
module rad4_booth_encoder (
  input  logic x1,
  input  logic x2,
  input  logic x3,
  output logic si,
  output logic di,
  output logic ni
);

  assign si = x2 ^ x3;
  assign di = (x1 & ~x2 & ~x3) | (~x1 & x2 & x3);
  assign ni = x1;

endmodule

// File: rtl/rad4_pp_select.sv
// Partial-product selector: picks 0, A or 2A at W+2 bits and negates when the digit is negative.
module rad4_pp_select #(
  parameter int W = 16
) (
  input  logic signed [W-1:0] a,
  input  logic                si,
  input  logic                di,
  input  logic                ni,
  output logic signed [W+1:0] pp
);

  logic signed [W+1:0] a_ext;
  logic signed [W+1:0] mag;

  always_comb begin
    a_ext = {{2{a[W-1]}}, a};
    mag   = '0;
    if (di) begin
      mag = a_ext <<< 1;
    end else if (si) begin
      mag = a_ext;
    end
    // Negating a zero magnitude yields zero, so digit 111 needs no special case.
    pp = ni ? -mag : mag;
  end

endmodule

// File: rtl/rad4_booth_seq_mult.sv
// Iterative signed radix-4 Booth multiplier: one digit per clock into a shift-and-add accumulator.
module rad4_booth_seq_mult
  import rad4_booth_pkg::*;
#(
  parameter int W = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic signed [W-1:0]   a,
  input  logic signed [W-1:0]   b,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic signed [2*W-1:0] p,
  output logic                  busy
);

  localparam int CW = cnt_w(W);
  localparam logic [CW-1:0] LAST = CW'(W / 2 - 1);

  if (!w_legal(W)) begin : g_bad_w
    $error("rad4_booth_seq_mult: W must be even and >= 4");
  end

  state_e              state_q, state_d;
  logic signed [W-1:0] a_q, a_d;
  logic [W:0]          bx_q, bx_d;
  logic signed [W+1:0] h_q, h_d;
  logic [W-1:0]        l_q, l_d;
  logic [CW-1:0]       cnt_q, cnt_d;

  logic                si, di, ni;
  logic signed [W+1:0] pp;
  logic signed [W+1:0] s;

  rad4_booth_encoder u_enc (
    .x1 (bx_q[2]),
    .x2 (bx_q[1]),
    .x3 (bx_q[0]),
    .si (si),
    .di (di),
    .ni (ni)
  );

  rad4_pp_select #(.W(W)) u_pp (
    .a  (a_q),
    .si (si),
    .di (di),
    .ni (ni),
    .pp (pp)
  );

  // W+2 bits of headroom keep the running sum exact even for (-2^(W-1))^2.
  assign s = h_q + pp;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid)      state_d = RUN;
      RUN:     if (cnt_q == LAST) state_d = DONE;
      DONE:    if (out_ready)     state_d = IDLE;
      default:                    state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    busy      = 1'b0;
    out_valid = 1'b0;
    p         = '0;
    case (state_q)
      IDLE: in_ready = 1'b1;
      RUN:  busy     = 1'b1;
      DONE: begin
        out_valid = 1'b1;
        p         = {h_q[W-1:0], l_q};
      end
      default: ;
    endcase
  end

  always_comb begin
    a_d   = a_q;
    bx_d  = bx_q;
    h_d   = h_q;
    l_d   = l_q;
    cnt_d = cnt_q;
    if (state_q == IDLE && in_valid) begin
      a_d   = a;
      bx_d  = {b, 1'b0};
      h_d   = '0;
      l_d   = '0;
      cnt_d = '0;
    end else if (state_q == RUN) begin
      // Arithmetic shift of {S,L} by one digit: the two low sum bits migrate into L.
      h_d   = {{2{s[W+1]}}, s[W+1:2]};
      l_d   = {s[1:0], l_q[W-1:2]};
      bx_d  = bx_q >> 2;
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_q   <= '0;
      bx_q  <= '0;
      h_q   <= '0;
      l_q   <= '0;
      cnt_q <= '0;
    end else begin
      a_q   <= a_d;
      bx_q  <= bx_d;
      h_q   <= h_d;
      l_q   <= l_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: tb/tb_rad4_booth_seq_mult.sv
// Directed table, backpressure/reset sequences and a randomized handshake run for rad4_booth_seq_mult.
module tb_rad4_booth_seq_mult;

  localparam int W = 16;

  logic          clk;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic          out_valid;
  logic          out_ready;
  logic [2*W-1:0] p;
  logic          busy;

  int checks = 0;
  int errors = 0;

  rad4_booth_seq_mult #(.W(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .p         (p),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [2*W-1:0] exp;
  } vec_t;

  vec_t tbl[12];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Accept one operand pair, wait for the product, check it and complete the handshake.
  task automatic run_one(input string name, input logic [W-1:0] va, input logic [W-1:0] vb,
                         input logic [2*W-1:0] exp, input bit timing);
    int n;
    int lat;
    int low;
    in_valid  = 1'b1;
    a         = va;
    b         = vb;
    out_ready = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    if (!in_ready) chk({name, "_accept_timeout"}, 0, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = W'($urandom);
    b = W'($urandom);
    low = in_ready ? 0 : 1;
    if (timing) chk({name, "_busy"}, busy, 1);
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1; lat++;
      if (!in_ready) low++;
    end
    chk({name, "_p"}, p, exp);
    if (timing) begin
      chk({name, "_latency"}, lat, W / 2);
      chk({name, "_in_ready_low"}, low, W / 2 + 1);
    end
    @(posedge clk); #1;
    if (timing) begin
      chk({name, "_out_valid_drop"}, out_valid, 0);
      chk({name, "_in_ready_back"}, in_ready, 1);
    end
  endtask

  initial begin
    logic [2*W-1:0] held;
    int n;

    tbl[0]  = '{16'h0003, 16'h0005, 32'h0000000F};
    tbl[1]  = '{16'hFFFF, 16'hFFFF, 32'h00000001};
    tbl[2]  = '{16'h8000, 16'h8000, 32'h40000000};
    tbl[3]  = '{16'h7FFF, 16'h8000, 32'hC0008000};
    tbl[4]  = '{16'h0000, 16'h8000, 32'h00000000};
    tbl[5]  = '{16'h8000, 16'h0000, 32'h00000000};
    tbl[6]  = '{16'h7FFF, 16'h7FFF, 32'h3FFF0001};
    tbl[7]  = '{16'h0001, 16'h8000, 32'hFFFF8000};
    tbl[8]  = '{16'hFFFE, 16'h0003, 32'hFFFFFFFA};
    tbl[9]  = '{16'h1234, 16'h0010, 32'h00012340};
    tbl[10] = '{16'h8000, 16'hFFFF, 32'h00008000};
    tbl[11] = '{16'h0007, 16'hFFF7, 32'hFFFFFFC1};

    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    #1;
    chk("reset_in_ready", in_ready, 1);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_busy", busy, 0);
    chk("reset_p", p, 0);
    repeat (3) @(posedge clk);
    #2 reset = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 12; i++) begin
      run_one($sformatf("vec%0d", i), tbl[i].a, tbl[i].b, tbl[i].exp, i == 0);
    end

    // Backpressure: product must hold while new operands wait outside.
    in_valid = 1'b1; a = 16'h0064; b = 16'hFF9C; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b1; a = 16'h0002; b = 16'h0003;
    n = 0;
    while (!out_valid && n < 40) begin
      @(posedge clk); #1; n++;
    end
    held = 32'hFFFFD8F0;
    for (int c = 0; c < 5; c++) begin
      chk($sformatf("bp_out_valid%0d", c), out_valid, 1);
      chk($sformatf("bp_p%0d", c), p, held);
      chk($sformatf("bp_in_ready%0d", c), in_ready, 0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_out_valid", out_valid, 0);
    chk("bp_release_in_ready", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("bp_next_busy", busy, 1);
    n = 0;
    while (!out_valid && n < 40) begin
      @(posedge clk); #1; n++;
    end
    chk("bp_next_p", p, 32'h00000006);
    @(posedge clk); #1;

    // Asynchronous reset in the middle of an operation.
    in_valid = 1'b1; a = 16'h1234; b = 16'h5678; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("arst_out_valid", out_valid, 0);
    chk("arst_in_ready", in_ready, 1);
    chk("arst_busy", busy, 0);
    chk("arst_p", p, 0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    run_one("after_reset", 16'h0007, 16'hFFF7, 32'hFFFFFFC1, 1'b1);

    // Randomized operands with random in_valid and out_ready gaps.
    begin
      logic [2*W-1:0] q[$];
      logic [2*W-1:0] exp;
      logic signed [2*W-1:0] ea;
      logic signed [2*W-1:0] eb;
      int acc = 0;
      int got = 0;
      int cyc = 0;
      bit fired = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      while (got < 1000 && cyc < 60000) begin
        @(negedge clk);
        cyc++;
        if (fired) begin
          in_valid = 1'b0;
          fired = 1'b0;
        end
        if (!in_valid && acc < 1000 && $urandom_range(3) != 0) begin
          in_valid = 1'b1;
          a = W'($urandom);
          b = W'($urandom);
        end
        out_ready = ($urandom_range(3) != 0);
        #1;
        if (in_valid && in_ready) begin
          ea = $signed(a);
          eb = $signed(b);
          q.push_back(ea * eb);
          acc++;
          fired = 1'b1;
        end
        if (out_valid && out_ready) begin
          if (q.size() == 0) begin
            chk("rand_unexpected_product", p, 0);
            errors++;
            got++;
          end else begin
            exp = q.pop_front();
            if (p !== exp) chk($sformatf("rand_p%0d", got), p, exp);
            else checks++;
            got++;
          end
        end
      end
      in_valid = 1'b0;
      chk("rand_products", got, 1000);
      chk("rand_accepted", acc, 1000);
      chk("rand_queue_empty", q.size(), 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
